// File: rtl/multicycle_control.sv
// Multi-cycle KGP-RISC control sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory
// handshake timeout, a sticky fault state, run/idle gating and a retire counter.
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int OP_RTYPE    = 0,
  parameter int OP_IMM      = 2,
  parameter int OP_LOAD     = 8,
  parameter int OP_STORE    = 16,
  parameter int OP_BRANCH   = 32,
  parameter int OP_JUMP     = 48,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic [1:0]       RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [1:0]       ALUSrc,
  output logic             RegDst,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             busy,
  output logic             instr_done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_NONE
  } class_e;

  state_e             state_q, state_d;
  class_e             class_q, class_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire_s;
  class_e             dec_class_s;

  function automatic class_e decode_f(input logic [OPW-1:0] op);
    if (op == OPW'(OP_RTYPE))       return C_RTYPE;
    else if (op == OPW'(OP_IMM))    return C_IMM;
    else if (op == OPW'(OP_LOAD))   return C_LOAD;
    else if (op == OPW'(OP_STORE))  return C_STORE;
    else if (op == OPW'(OP_BRANCH)) return C_BRANCH;
    else if (op == OPW'(OP_JUMP))   return C_JUMP;
    else                            return C_NONE;
  endfunction

  // ALU B-operand source for an instruction class, held from EXEC through WB
  function automatic logic [1:0] alu_src_f(input class_e c);
    case (c)
      C_IMM, C_LOAD, C_STORE: return 2'b01;
      C_JUMP:                 return 2'b10;
      default:                return 2'b00;
    endcase
  endfunction

  // State, latched class, wait counter, fault code and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      class_q      <= C_RTYPE;
      wait_q       <= '0;
      fault_code_q <= 2'b00;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      wait_q       <= wait_d;
      fault_code_q <= fault_code_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and Moore output decode; branch pc_write and store retire see inputs directly
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    wait_d       = wait_q;
    fault_code_d = fault_code_q;
    cnt_d        = cnt_q;
    retire_s     = 1'b0;
    dec_class_s  = decode_f(opcode);
    RegWrite     = 2'b00;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrc       = 2'b00;
    RegDst       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    instr_done   = 1'b0;
    busy         = (state_q != S_IDLE) && (state_q != S_FAULT);
    fault        = (state_q == S_FAULT);
    fault_code   = fault_code_q;
    instr_count  = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src   = 2'b00;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (dec_class_s == C_NONE) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b01;
        end else begin
          class_d = dec_class_s;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUSrc = alu_src_f(class_q);
        RegDst = (class_q == C_RTYPE);
        wait_d = '0;
        case (class_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_write = zero;
            pc_src   = 2'b01;
            retire_s = 1'b1;
          end
          C_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_WB;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        ALUSrc   = alu_src_f(class_q);
        MemRead  = (class_q == C_LOAD);
        MemWrite = (class_q == C_STORE);
        // An ack in the final allowed cycle takes priority over the timeout
        if (mem_ack) begin
          if (class_q == C_STORE) retire_s = 1'b1;
          else                    state_d  = S_WB;
        end else if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1))) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        ALUSrc   = alu_src_f(class_q);
        RegDst   = (class_q == C_RTYPE);
        RegWrite = (class_q == C_JUMP) ? 2'b10 : 2'b01;
        MemtoReg = (class_q == C_LOAD);
        retire_s = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    if (retire_s) begin
      instr_done = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
      state_d    = run ? S_FETCH : S_IDLE;
    end else begin
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, the timeout
// boundary, illegal opcode, mid-MEM reset and counter wrap with a 2-bit counter.
module tb_multicycle_control;

  logic        clk, rst_n, run, zero, mem_ack;
  logic [5:0]  opcode;
  logic [1:0]  RegWrite, ALUSrc, pc_src, fault_code;
  logic        MemRead, MemWrite, MemtoReg, RegDst, ir_write, pc_write;
  logic        busy, instr_done, fault;
  logic [15:0] instr_count;

  logic [1:0]  c2_RegWrite, c2_ALUSrc, c2_pc_src, c2_fault_code, c2_instr_count;
  logic        c2_MemRead, c2_MemWrite, c2_MemtoReg, c2_RegDst, c2_ir_write, c2_pc_write;
  logic        c2_busy, c2_instr_done, c2_fault;

  logic [16:0] outs, c2_outs;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0, rd_cycles, wr_cycles;
  logic [1:0]  exp_small [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  assign outs = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ir_write,
                 pc_write, pc_src, busy, instr_done, fault, fault_code};
  assign c2_outs = {c2_RegWrite, c2_MemRead, c2_MemWrite, c2_MemtoReg, c2_ALUSrc, c2_RegDst,
                    c2_ir_write, c2_pc_write, c2_pc_src, c2_busy, c2_instr_done, c2_fault,
                    c2_fault_code};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .RegDst(RegDst), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .busy(busy), .instr_done(instr_done), .fault(fault),
    .fault_code(fault_code), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .RegWrite(c2_RegWrite), .MemRead(c2_MemRead), .MemWrite(c2_MemWrite),
    .MemtoReg(c2_MemtoReg), .ALUSrc(c2_ALUSrc), .RegDst(c2_RegDst),
    .ir_write(c2_ir_write), .pc_write(c2_pc_write), .pc_src(c2_pc_src), .busy(c2_busy),
    .instr_done(c2_instr_done), .fault(c2_fault), .fault_code(c2_fault_code),
    .instr_count(c2_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ack = 1'b0;
    tick(); tick(); #1;
    chk("reset_outs", outs, 32'h0);
    chk("reset_cnt", instr_count, 32'h0);
    chk("reset_outs_c2", c2_outs, 32'h0);

    // rtype: FETCH, DECODE, EXEC, WB
    rst_n = 1'b1; run = 1'b1; opcode = 6'd0;
    tick(); #1;
    chk("rt_fetch", {ir_write, pc_write, pc_src, busy}, 32'b1_1_00_1);
    tick(); #1;
    chk("rt_decode", {ir_write, pc_write, RegWrite, busy}, 32'b0_0_00_1);
    tick(); #1;
    chk("rt_exec", {ALUSrc, RegDst, RegWrite, instr_done}, 32'b00_1_00_0);
    tick(); opcode = 6'd8; #1;
    chk("rt_wb", {RegWrite, RegDst, ALUSrc, MemtoReg, instr_done}, 32'b01_1_00_0_1);

    // load with three wait cycles, back-to-back with the rtype
    tick(); t0 = cyc; #1;
    chk("ld_fetch_nobubble", {ir_write, pc_write}, 32'b11);
    chk("cnt_after_rt", instr_count, 32'd1);
    tick(); tick(); #1;
    chk("ld_exec", {ALUSrc, RegDst, MemRead}, 32'b01_0_0);
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); mem_ack = (i == 3); #1;
      if (MemRead) rd_cycles++;
      if (i == 3) chk("ld_ack_cycle", {MemRead, instr_done}, 32'b10);
    end
    tick(); mem_ack = 1'b0; run = 1'b0; #1;
    chk("ld_wb", {RegWrite, MemtoReg, MemRead, ALUSrc, instr_done}, 32'b01_1_0_01_1);
    chk("ld_memread_cycles", rd_cycles, 32'd4);
    chk("ld_latency", cyc - t0 + 1, 32'd8);
    tick(); #1;
    chk("idle_outs", outs, 32'h0);
    chk("cnt_after_ld", instr_count, 32'd2);

    // branch taken then not taken
    opcode = 6'd32; zero = 1'b1; run = 1'b1;
    tick(); tick(); tick(); #1;
    chk("br_taken_exec", {pc_write, pc_src, instr_done, RegWrite}, 32'b1_01_1_00);
    zero = 1'b0; #1;
    chk("br_zero_follow", pc_write, 32'b0);
    tick(); #1;
    chk("br2_fetch", ir_write, 32'b1);
    tick(); tick(); #1;
    chk("br_nt_exec", {pc_write, pc_src, instr_done, RegWrite}, 32'b0_01_1_00);
    run = 1'b0;
    tick(); #1;
    chk("cnt_after_br", {busy, instr_count}, {1'b0, 16'd4});

    // store acked in the last allowed MEM cycle: ack wins over timeout
    opcode = 6'd16; run = 1'b1;
    tick(); tick(); tick(); #1;
    chk("st_exec", {ALUSrc, MemWrite}, 32'b01_0);
    wr_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      tick(); mem_ack = (i == 14);
      if (i == 14) run = 1'b0;
      #1;
      if (MemWrite) wr_cycles++;
      if (i == 14) chk("st_ack_retire", {instr_done, fault}, 32'b10);
    end
    chk("st_memwrite_cycles", wr_cycles, 32'd15);
    tick(); mem_ack = 1'b0; #1;
    chk("st_no_fault", {busy, fault, fault_code}, 32'b0_0_00);
    chk("cnt_after_st", instr_count, 32'd5);

    // store with no ack: timeout fault after 15 MEM cycles
    run = 1'b1;
    tick(); tick(); tick();
    wr_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      tick(); #1;
      if (MemWrite) wr_cycles++;
    end
    chk("to_memwrite_cycles", wr_cycles, 32'd15);
    tick(); #1;
    chk("to_fault", {MemWrite, fault, fault_code, busy}, 32'b0_1_10_0);
    mem_ack = 1'b1;
    tick(); tick(); mem_ack = 1'b0;
    tick(); #1;
    chk("to_fault_held", {fault, fault_code, busy, instr_count}, {1'b1, 2'b10, 1'b0, 16'd5});

    // reset clears fault, then illegal opcode
    rst_n = 1'b0;
    tick(); #1;
    chk("rst_clears_fault", {outs, instr_count}, 32'h0);
    rst_n = 1'b1; opcode = 6'd5; run = 1'b1;
    tick(); tick(); #1;
    chk("ill_decode", {RegWrite, MemWrite, fault}, 32'b00_0_0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("ill_fault", {fault, fault_code, busy, RegWrite, MemWrite}, 32'b1_01_0_00_0);
    end

    // counter wrap with CNT_W=2, then reset mid-MEM of a load
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; opcode = 6'd0; run = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick(); tick(); tick();
      if (k == 5) opcode = 6'd8;
      #1;
      chk("cw_retire", instr_done, 32'b1);
      tick(); #1;
      chk("cw_cnt16", instr_count, k);
      chk("cw_cnt2", c2_instr_count, exp_small[k-1]);
    end
    tick(); tick(); tick(); #1;
    chk("mr_in_mem", {MemRead, busy}, 32'b11);
    rst_n = 1'b0;
    tick(); #1;
    chk("mr_outs", outs, 32'h0);
    chk("mr_cnt", instr_count, 32'h0);
    chk("mr_cnt_c2", c2_instr_count, 32'h0);
    rst_n = 1'b1; run = 1'b0;
    tick(); #1;
    chk("mr_idle", outs, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle successor to the single-cycle KGP-RISC `Control` decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, reusing the same datapath control outputs (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst). It adds the following beyond the single-cycle decoder:
- a data-memory handshake with timeout;
- an illegal-opcode fault state;
- run/idle gating;
- a retired-instruction counter.

It sits between the instruction register and the datapath and block-memory control.

## Interface
Parameters:
- OPW, 6: opcode width.
- OP_RTYPE, 0: register ALU opcode.
- OP_IMM, 2: immediate ALU opcode.
- OP_LOAD, 8: load opcode.
- OP_STORE, 16: store opcode.
- OP_BRANCH, 32: conditional branch (taken when zero=1).
- OP_JUMP, 48: jump-and-link opcode.
- MEM_TIMEOUT, 15: max MEM cycles without mem_ack before fault; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- run, input, 1: allow a new instruction to start.
- opcode, input, OPW: opcode field of the instruction register; sampled in DECODE.
- zero, input, 1: ALU zero flag; sampled in EXEC for branches.
- mem_ack, input, 1: data memory completion.
- RegWrite, output, 2: 00 none, 01 write rd, 10 write link register.
- MemRead, output, 1: load request.
- MemWrite, output, 1: store request.
- MemtoReg, output, 1: write-back from memory.
- ALUSrc, output, 2: 00 register, 01 immediate, 10 PC.
- RegDst, output, 1: 1 = rd, 0 = rt.
- ir_write, output, 1: load the instruction register.
- pc_write, output, 1: update the PC.
- pc_src, output, 2: 00 PC+4, 01 branch target, 10 jump target.
- busy, output, 1: state is not IDLE and not FAULT.
- instr_done, output, 1: one-cycle retire pulse.
- fault, output, 1: sticky fault flag.
- fault_code, output, 2: 01 illegal opcode, 10 memory timeout.
- instr_count, output, CNT_W: number of retired instructions.

## Operation
- States and transitions:
  - IDLE → FETCH when run=1.
  - FETCH → DECODE.
  - DECODE → EXEC, or → FAULT if the opcode matches no OP_* parameter.
  - EXEC → MEM for load/store.
  - EXEC → WB for rtype/imm/jump.
  - EXEC retires a branch directly.
  - MEM → WB (load) or retire (store) on mem_ack.
  - WB retires.
  - Retire goes → FETCH if run=1, else → IDLE.
  - FAULT is held until rst_n=0.
- FETCH asserts ir_write=1, pc_write=1, pc_src=00.
- EXEC drives ALUSrc by class: rtype 00, imm/load/store 01, branch 00, jump 10. ALUSrc is held through MEM and WB.
- EXEC, branch: pc_write=zero, pc_src=01.
- EXEC, jump: pc_write=1, pc_src=10.
- MEM:
  - MemRead (load) or MemWrite (store) stays high every MEM cycle until and including the mem_ack cycle.
  - mem_ack outside MEM is ignored.
- WB, rtype/imm: RegWrite=01, MemtoReg=0.
- WB, load: RegWrite=01, MemtoReg=1.
- WB, jump: RegWrite=10.
- RegDst=1 for rtype only; it is 0 otherwise.
- All outputs not listed for a state are 0.
- Timeout:
  - The wait counter clears on MEM entry and increments each MEM cycle without mem_ack.
  - When it reaches MEM_TIMEOUT, the FSM enters FAULT with fault_code=10.
  - MemRead/MemWrite drop in the FAULT cycle.
- Illegal opcode gives fault_code=01. fault=1 and fault_code stay frozen until reset.
- instr_done pulses in the retiring cycle: the WB cycle, the store's mem_ack cycle, or the branch's EXEC cycle.
- instr_count increments on instr_done and wraps modulo 2^CNT_W.
- Reset (rst_n=0 at an edge), from any state including mid-MEM:
  - state=IDLE; every output=0.
  - instr_count=0, fault=0, fault_code=00, wait counter=0.

## Timing
- All outputs are registered/Moore, decoded from the current state plus the latched opcode class. No combinational path from mem_ack or zero to RegWrite.
  - Exception: pc_write in branch EXEC follows zero combinationally.
  - Exception: MemRead/MemWrite stay asserted in the mem_ack cycle.
- Cycles from FETCH to retire, with run held at 1:
  - rtype/imm/jump: 4.
  - branch: 3.
  - store: 4+w.
  - load: 5+w, where w = MEM cycles before the mem_ack cycle.
- Back-to-back instructions: FETCH of the next instruction immediately follows the retire cycle; no bubble.
- run is sampled only in IDLE and at retire. Dropping run mid-instruction does not abort it.
- mem_ack arriving in the cycle the counter hits MEM_TIMEOUT: the ack wins; no fault.

## Test plan
- Reset then run=1, opcode=0: FETCH,DECODE,EXEC,WB over 4 cycles. WB shows RegWrite=01, RegDst=1, ALUSrc=00. instr_done at cycle 4; instr_count=1.
- opcode=8, mem_ack after 3 MEM cycles: MemRead high for exactly 4 cycles. WB gives RegWrite=01, MemtoReg=1. Latency 8.
- opcode=32 with zero=1, then zero=0: pc_write=1 with pc_src=01 in EXEC only for zero=1. Each instruction retires in 3 cycles with RegWrite=00.
- opcode=16, mem_ack never arrives, MEM_TIMEOUT=15: MemWrite high for 15 cycles, then fault=1 and fault_code=10. busy=0 thereafter, held until rst_n=0.
- opcode=5 (illegal): FAULT entered after DECODE with fault_code=01; no RegWrite/MemWrite ever asserted.
- rst_n=0 during the MEM of a load, and separately CNT_W=2 with 5 retires:
  - Reset: all outputs and instr_count read 0 the next cycle.
  - Counter: instr_count sequence 1,2,3,0,1.
